riscv_run_ctrl: RTL
===================

RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of the program-counter input and of halt_pc.
REQ-002 SHALL have parameter CNT_W, default 32: width of cycle_count.
REQ-003 SHALL have parameter RESET_CYCLES, default 4: number of cycles core_reset is held in the RESET state (minimum 1).
REQ-004 SHALL have parameter MAX_CYCLES, default 1000: run-cycle budget before timeout (minimum 1, less than 2^CNT_W).
REQ-005 SHALL have parameter STALL_LIMIT, default 8: number of consecutive unchanged-PC cycles that counts as stuck (minimum 1).
REQ-006 SHALL have parameter HALT_INSN, default 32'h00100073 (ebreak): instruction encoding that ends a run.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port start, input, 1 bit: single-cycle request to begin a run.
REQ-010 SHALL have port pc_in, input, XLEN bits: core program counter.
REQ-011 SHALL have port instr_in, input, 32 bits: instruction the core is currently fetching.
REQ-012 SHALL have port core_reset, output, 1 bit: active-high reset driven to the core.
REQ-013 SHALL have port running, output, 1 bit: high while in the RUN state.
REQ-014 SHALL have port done, output, 1 bit: high while in the DONE state.
REQ-015 SHALL have port status, output, 2 bits: 00 none, 01 halted, 10 timeout, 11 stuck.
REQ-016 SHALL have port cycle_count, output, CNT_W bits: number of run cycles taken.
REQ-017 SHALL have port halt_pc, output, XLEN bits: pc_in captured at termination.

Function
REQ-018 SHALL implement the FSM states IDLE, RESET, RUN and DONE; all outputs SHALL be registered or decoded from state only.
REQ-019 IDLE: core_reset=1; start -> RESET; otherwise stay in IDLE.
REQ-020 RESET: core_reset=1 for exactly RESET_CYCLES cycles, then -> RUN; start is ignored; on entry, status, cycle_count, the stall counter and the prev-PC valid flag SHALL clear to 0.
REQ-021 RUN: core_reset=0 and running=1; cycle_count SHALL increment on every rising edge spent in RUN, including the terminating edge; start is ignored.
REQ-022 RUN, halt: instr_in==HALT_INSN -> DONE with status=01 and halt_pc=pc_in.
REQ-023 RUN, stuck: prev_pc SHALL be captured every RUN cycle and the valid flag set after the first RUN cycle.
REQ-024 RUN, stuck: while the valid flag is set and pc_in==prev_pc, the stall counter SHALL increment; any mismatch SHALL clear it to 0.
REQ-025 RUN, stuck: a match while stall counter==STALL_LIMIT-1 -> DONE with status=11 and halt_pc=pc_in.
REQ-026 RUN, timeout: cycle_count==MAX_CYCLES-1 with no other termination -> DONE with status=10 and halt_pc=pc_in, leaving cycle_count==MAX_CYCLES.
REQ-027 Termination priority when several conditions hold in the same cycle: halt > stuck > timeout.
REQ-028 DONE: done=1 and core_reset=1; status, cycle_count and halt_pc SHALL hold; start -> RESET (new run); otherwise stay in DONE.
REQ-029 cycle_count SHALL NOT wrap; the MAX_CYCLES bound guarantees this.

Reset
REQ-030 Asserting reset SHALL, immediately and regardless of clk, force state=IDLE, core_reset=1, running=0, done=0, status=00, cycle_count=0, halt_pc=0, and clear the stall counter, prev_pc and valid flag.
REQ-031 Reset asserted mid-RUN or mid-RESET SHALL abort the run with no status recorded; after release the block SHALL wait in IDLE for start.

Verification
REQ-032 Reset release, start pulse, halt: start -> core_reset high for 4 cycles; then instr_in=32'h00100073 on the 3rd RUN cycle, pc_in=0x08 -> done=1, status=01, cycle_count=3, halt_pc=0x08.
REQ-033 Timeout: PC advancing by 4 each cycle, HALT_INSN never seen -> after 1000 RUN cycles, status=10, cycle_count=1000, running=0.
REQ-034 Stuck: pc_in held at 0x40 from the first RUN cycle -> status=11 on the 9th RUN edge, cycle_count=9, halt_pc=0x40.
REQ-035 Simultaneous events: HALT_INSN presented on the same edge that would trigger stuck -> status=01.
REQ-036 Mid-run abort and restart: reset asserted during RUN at cycle 50 -> IDLE, all outputs at reset values; a fresh start -> cycle_count restarts at 0, status=00 until termination.
REQ-037 Restart from DONE: start pulsed in DONE -> RESET for 4 cycles, status and cycle_count cleared, new run proceeds normally; start pulsed in RUN -> no effect.

Source files
------------

// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: run controller that resets a core, runs it, and records how the run ended.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               single-cycle request to begin a run (honoured in IDLE and DONE)
//   pc_in, instr_in     core program counter and instruction being fetched
//   core_reset          reset to the core, low only while running
//   running, done       RUN / DONE state flags
//   status              00 none, 01 halted, 10 timeout, 11 stuck
//   cycle_count         run cycles taken, including the terminating one
//   halt_pc             pc_in captured on the terminating edge
module riscv_run_ctrl #(
  parameter int          XLEN         = 32,
  parameter int          CNT_W        = 32,
  parameter int          RESET_CYCLES = 4,
  parameter int          MAX_CYCLES   = 1000,
  parameter int          STALL_LIMIT  = 8,
  parameter logic [31:0] HALT_INSN    = 32'h00100073
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic            core_reset,
  output logic            running,
  output logic            done,
  output logic [1:0]      status,
  output logic [CNT_W-1:0] cycle_count,
  output logic [XLEN-1:0] halt_pc
);
  localparam int RW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  localparam int SW = STALL_LIMIT > 1 ? $clog2(STALL_LIMIT) : 1;
  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;
  state_t          state_q;
  logic [RW-1:0]   rst_cnt_q;
  logic [SW-1:0]   stall_q;
  logic [XLEN-1:0] prev_pc_q;
  logic            valid_q;
  logic [1:0]      status_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] halt_pc_q;
  logic            match;
  logic [1:0]      status_d;
  // Termination code for this edge; the ternary order encodes halt > stuck > timeout.
  always_comb begin
    match    = valid_q && pc_in == prev_pc_q;
    status_d = instr_in == HALT_INSN                      ? 2'b01 :
               match && stall_q == SW'(STALL_LIMIT - 1)   ? 2'b11 :
               cnt_q == CNT_W'(MAX_CYCLES - 1)            ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      stall_q   <= '0;
      prev_pc_q <= '0;
      valid_q   <= 1'b0;
      status_q  <= 2'b00;
      cnt_q     <= '0;
      halt_pc_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          state_q   <= S_RST;
          rst_cnt_q <= '0;
          stall_q   <= '0;
          valid_q   <= 1'b0;
          status_q  <= 2'b00;
          cnt_q     <= '0;
        end
        S_RST: begin
          if (rst_cnt_q == RW'(RESET_CYCLES - 1)) state_q <= S_RUN;
          else rst_cnt_q <= rst_cnt_q + RW'(1);
        end
        S_RUN: begin
          cnt_q     <= cnt_q + CNT_W'(1);
          prev_pc_q <= pc_in;
          valid_q   <= 1'b1;
          stall_q   <= match ? stall_q + SW'(1) : '0;
          if (status_d != 2'b00) begin
            state_q   <= S_DONE;
            status_q  <= status_d;
            halt_pc_q <= pc_in;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign core_reset  = state_q != S_RUN;
  assign running     = state_q == S_RUN;
  assign done        = state_q == S_DONE;
  assign status      = status_q;
  assign cycle_count = cnt_q;
  assign halt_pc     = halt_pc_q;
endmodule
